// File: rtl/pipe_stage.sv
// pipe_stage: elastic valid/ready pipeline register with a 2-entry skid
// buffer, synchronous flush and a saturating back-pressure counter.
// in_ready comes straight from a flop so no ready path crosses the stage.
module pipe_stage #(
    parameter int DATA_W = 38,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    input  logic              stall_clr
);

    // State encoding is {main_v, skid_v}; 2'b01 is unreachable.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_TWO   = 2'b11
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_main_d;
    logic [DATA_W-1:0] r_skid_d;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_main_v;
    logic w_skid_v;
    logic w_acc;
    logic w_drn;
    logic w_ld_main_in;
    logic w_ld_main_skid;
    logic w_ld_skid;
    logic w_stall;

    assign w_main_v = r_state[1];
    assign w_skid_v = r_state[0];
    assign w_acc    = in_valid & r_in_ready;
    assign w_drn    = w_main_v & out_ready;
    assign w_stall  = w_main_v & ~out_ready & ~flush;

    assign in_ready  = r_in_ready;
    assign out_valid = w_main_v;
    assign out_data  = r_main_d;
    assign occupancy = {1'b0, w_main_v} + {1'b0, w_skid_v};
    assign stall_cnt = r_stall_cnt;

    // State register; ready tracks the next skid state so it is a pure flop
    // and is held low throughout reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= ~w_state_nxt[0];
        end
    end

    // Next state and data-load strobes; flush wins over every transition.
    always_comb begin
        w_state_nxt    = r_state;
        w_ld_main_in   = 1'b0;
        w_ld_main_skid = 1'b0;
        w_ld_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = S_EMPTY;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        w_ld_main_in = 1'b1;
                        w_state_nxt  = S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_acc && w_drn) begin
                        w_ld_main_in = 1'b1;
                    end else if (w_acc) begin
                        w_ld_skid   = 1'b1;
                        w_state_nxt = S_TWO;
                    end else if (w_drn) begin
                        w_state_nxt = S_EMPTY;
                    end
                end
                S_TWO: begin
                    if (w_drn) begin
                        w_ld_main_skid = 1'b1;
                        w_state_nxt    = S_ONE;
                    end
                end
                default: w_state_nxt = S_EMPTY;
            endcase
        end
    end

    // Payload registers load only on the strobes above.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_main_d <= '0;
            r_skid_d <= '0;
        end else begin
            if (w_ld_main_in)
                r_main_d <= in_data;
            else if (w_ld_main_skid)
                r_main_d <= r_skid_d;
            if (w_ld_skid)
                r_skid_d <= in_data;
        end
    end

    // Saturating count of stalled cycles; clear has priority.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_stall_cnt <= '0;
        else if (stall_clr)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}}))
            r_stall_cnt <= r_stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_pipe_stage.sv
// tb_pipe_stage: directed and random checks of pipe_stage (CNT_W=4 so the
// counter saturates quickly).
module tb_pipe_stage;

    localparam int DATA_W = 38;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;
    logic              stall_clr;

    int n_chk = 0;
    int n_err = 0;

    pipe_stage #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt),
        .stall_clr (stall_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DATA_W-1:0] sn_in;
        logic [DATA_W-1:0] exp_out;
        logic [DATA_W-1:0] prev;
        int                cnt_m;
        logic              acc_b, drn_b, stall_b;

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0;
        out_ready = 1'b0; stall_clr = 1'b0;

        // 1. reset then stream
        repeat (3) step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        #2 rst = 1'b1;
        step();
        chk("post_rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1;
            in_data  = DATA_W'(i);
            step();
            chk("stream_data", out_data, i);
            chk("stream_valid", out_valid, 1);
            chk("stream_occ", occupancy, 1);
            chk("stream_in_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("stream_drained", out_valid, 0);
        chk("stream_stall_cnt", stall_cnt, 0);

        // 2. back-pressure into the skid entry
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 'h11;
        step();
        chk("bp_a_occ", occupancy, 1);
        chk("bp_a_in_ready", in_ready, 1);
        in_data = 'h22;
        step();
        chk("bp_b_occ", occupancy, 2);
        chk("bp_b_in_ready", in_ready, 0);
        chk("bp_b_data", out_data, 'h11);
        in_valid = 1'b0;
        repeat (3) step();
        chk("bp_hold_data", out_data, 'h11);
        chk("bp_stall_cnt", stall_cnt, 4);
        out_ready = 1'b1;
        step();
        chk("bp_drain_b", out_data, 'h22);
        chk("bp_drain_occ", occupancy, 1);
        chk("bp_drain_in_ready", in_ready, 1);
        step();
        chk("bp_empty", out_valid, 0);
        chk("bp_stall_keep", stall_cnt, 4);
        stall_clr = 1'b1;
        step();
        stall_clr = 1'b0;
        chk("bp_stall_clr", stall_cnt, 0);

        // 3. flush while full, with a beat offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 'h11;
        step();
        in_data = 'h22;
        step();
        chk("fl_full", occupancy, 2);
        in_data = 'h33; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_out_valid", out_valid, 0);
        chk("fl_occ", occupancy, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_stall_cnt", stall_cnt, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fl_no_c", out_valid, 0);
        end

        // 4. random valid/ready with sequence-number payload
        sn_in = '0; exp_out = '0; cnt_m = 0;
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            in_data   = sn_in;
            #1;
            acc_b   = in_valid & in_ready;
            drn_b   = out_valid & out_ready;
            stall_b = out_valid & ~out_ready;
            prev    = out_data;
            if (drn_b) begin
                chk("rnd_order", out_data, exp_out);
                exp_out++;
            end
            step();
            if (acc_b) begin
                sn_in++;
                cnt_m++;
            end
            if (drn_b) cnt_m--;
            if (stall_b) begin
                chk("rnd_hold_v", out_valid, 1);
                chk("rnd_hold_d", out_data, prev);
            end
            chk("rnd_occ", occupancy, cnt_m);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        chk("rnd_final_occ", occupancy, 0);
        chk("rnd_all_out", exp_out + DATA_W'(cnt_m), sn_in);

        // 5. counter saturation and clear (CNT_W=4)
        out_ready = 1'b0; stall_clr = 1'b1;
        in_valid = 1'b1; in_data = 'h44;
        step();
        in_valid = 1'b0; stall_clr = 1'b0;
        chk("sat_start", stall_cnt, 0);
        repeat (20) step();
        chk("sat_15", stall_cnt, 15);
        stall_clr = 1'b1;
        step();
        chk("sat_clr", stall_cnt, 0);
        step();
        chk("sat_clr_with_stall", stall_cnt, 0);
        stall_clr = 1'b0;
        step();
        chk("sat_resume", stall_cnt, 1);

        // 6. async reset while full
        in_valid = 1'b1; in_data = 'h55;
        step();
        in_valid = 1'b0;
        chk("ar_full", occupancy, 2);
        #2 rst = 1'b0;
        #1;
        chk("ar_out_valid", out_valid, 0);
        chk("ar_occ", occupancy, 0);
        chk("ar_in_ready", in_ready, 0);
        chk("ar_out_data", out_data, 0);
        chk("ar_stall_cnt", stall_cnt, 0);
        step();
        #2 rst = 1'b1;
        step();
        chk("ar_rel_in_ready", in_ready, 1);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 'h66;
        step();
        in_valid = 1'b0;
        chk("ar_beat_v", out_valid, 1);
        chk("ar_beat_d", out_data, 'h66);
        step();
        chk("ar_beat_gone", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage.md
Name: pipe_stage

Overview:
- Parametrised, elastic successor to the fixed EX/MEM-style pipeline latch.
- Carries an opaque payload (e.g. {wd, wreg, wdata}) between two pipeline stages using a valid/ready handshake.
- Includes a 2-entry skid buffer so in_ready is driven from a register, with no combinational ready path.
- Adds synchronous flush (branch/exception squash) and a saturating back-pressure counter for performance monitoring.

Parameters:
- DATA_W, 38, payload width in bits (5-bit wd + 1-bit wreg + 32-bit wdata).
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- flush  in  1  synchronous squash of all held entries.
- in_valid  in  1  upstream presents in_data.
- in_ready  out  1  stage can accept a beat.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  main entry holds a valid payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  DATA_W  payload of the main entry.
- occupancy  out  2  number of valid entries (0..2).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating.
- stall_clr  in  1  synchronous clear of stall_cnt.

Behaviour:
- Storage: main register (main_v, main_d) and skid register (skid_v, skid_d).
  - out_valid = main_v; out_data = main_d.
  - in_ready = ~skid_v, registered state only.
  - occupancy = main_v + skid_v.
- Beat definitions:
  - acc = in_valid & in_ready.
  - drn = out_valid & out_ready.
- States (main_v, skid_v): EMPTY (0,0), ONE (1,0), TWO (1,1). (0,1) is illegal and never reached.
- EMPTY:
  - acc → main_d <= in_data, go ONE.
  - Otherwise stay EMPTY.
- ONE:
  - acc & drn → main_d <= in_data, stay ONE.
  - acc & ~drn → skid_d <= in_data, go TWO.
  - ~acc & drn → go EMPTY.
  - Otherwise hold.
- TWO (in_ready = 0, so acc is impossible):
  - drn → main_d <= skid_d, go ONE.
  - Otherwise hold.
- Ordering: FIFO, no reordering or duplication. Latency is 1 cycle from acc to out_valid when empty.
- Hold rule: while out_valid=1 and out_ready=0, out_data is stable.
- Data registers load only on the transitions listed above. The data value is don't-care when its valid bit is 0.
- flush=1 at an edge:
  - main_v <= 0 and skid_v <= 0.
  - Any acc or drn in that cycle is discarded; the upstream beat counts as consumed.
  - flush takes priority over every other transition.
  - stall_cnt is unaffected.
- stall_cnt:
  - Increments by 1 on each edge where out_valid & ~out_ready & ~flush.
  - Saturates at 2^CNT_W-1.
  - stall_clr has priority and sets it to 0.
  - The counter sees the pre-edge out_valid.
- Reset (rst=0, asynchronous, any time including mid-transfer):
  - main_v = skid_v = 0, main_d = skid_d = 0, stall_cnt = 0.
  - Hence out_valid = 0, out_data = 0, occupancy = 0.
  - in_ready is forced to 0 while rst=0, and is 1 in the first cycle after release.
- No X propagation: all outputs are defined from reset onward.

Test Plan:
1. Reset then stream: hold rst=0 for 3 cycles; check in_ready=0, out_valid=0, out_data=0. Release, drive beats 0x01..0x0A with out_ready=1 continuously → out_data 0x01..0x0A on consecutive cycles, 1-cycle latency, occupancy=1 throughout.
2. Back-pressure/skid: out_ready=0 with beats A=0x11, B=0x22 offered → in_ready falls after B and occupancy=2. Set out_ready=1 → A then B delivered in order, in_ready returns to 1 and no beat is lost. stall_cnt equals the number of stalled cycles (e.g. 4).
3. Flush: in state TWO (A, B held) assert flush for 1 cycle while in_valid=1 with C=0x33 → next cycle out_valid=0, occupancy=0, C never appears on the output.
4. Random valid/ready: random in_valid/out_ready at 50% for 10,000 cycles with payload = sequence number → output is strictly in order with no gaps/duplicates, out_data stable under stall, occupancy never reaches 3.
5. Counter saturation/clear: with CNT_W=4, stall for 20 cycles → stall_cnt=15. Pulse stall_clr → 0. Assert stall_clr together with a stall → 0.
6. Async reset mid-operation: drop rst asynchronously (between edges) while in TWO → out_valid and occupancy go to 0 immediately, without waiting for a clock edge. After release the first beat flows normally.
